// File: rtl/spmmio_timer.sv
// Memory-mapped countdown timer with a 16-bit prescaler, auto-reload and a level irq.
// Optional free-running CYCLES counter at address 5 when SPMMIO_TIMER_CYCLES_EN is defined.
module spmmio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:3]  adr,
    input  logic        cs,
    input  logic [0:3]  sel,
    input  logic        we,
    input  logic [0:31] d,
    output logic [0:31] q,
    output logic        irq
);

    localparam logic [3:0] ADR_CTRL     = 4'd0;
    localparam logic [3:0] ADR_STATUS   = 4'd1;
    localparam logic [3:0] ADR_PRESCALE = 4'd2;
    localparam logic [3:0] ADR_RELOAD   = 4'd3;
    localparam logic [3:0] ADR_COUNT    = 4'd4;
    localparam logic [3:0] ADR_CYCLES   = 4'd5;

    // Bus uses MSB-first numbering; everything internal is LSB-at-0.
    logic [3:0]  a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;

    assign a  = adr;
    assign be = sel;
    assign wd = d;
    assign q  = rd;

    logic        en_q, en_d;
    logic        ar_q, ar_d;
    logic        ie_q, ie_d;
    logic        exp_q, exp_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] pre_q, pre_d;
    logic [31:0] reload_q, reload_d;
    logic [31:0] count_q, count_d;

    logic wr, wr_ctrl, wr_status, wr_presc, wr_reload, wr_count;
    logic tick, tick_live, expire;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  en);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = en[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

    assign wr        = cs & we;
    assign wr_ctrl   = wr && (a == ADR_CTRL);
    assign wr_status = wr && (a == ADR_STATUS);
    assign wr_presc  = wr && (a == ADR_PRESCALE);
    assign wr_reload = wr && (a == ADR_RELOAD);
    assign wr_count  = wr && (a == ADR_COUNT);

    // A COUNT write swallows a coincident tick entirely, including its expiry.
    assign tick      = en_q && (pre_q == presc_q);
    assign tick_live = tick && !wr_count;
    assign expire    = tick_live && (count_q == 32'd0);

    always_comb begin
        pre_d = (!en_q || wr_presc || wr_count || tick) ? 16'd0 : pre_q + 16'd1;

        count_d = count_q;
        if (tick_live) begin
            if (count_q != 32'd0)
                count_d = count_q - 32'd1;
            else if (ar_q)
                count_d = reload_q;
        end
        if (wr_count)
            count_d = merge_bytes(count_q, wd, be);

        en_d = en_q;
        ar_d = ar_q;
        ie_d = ie_q;
        if (expire && !ar_q)
            en_d = 1'b0;
        if (wr_ctrl && be[0]) begin
            en_d = wd[0];
            ar_d = wd[1];
            ie_d = wd[2];
        end

        // Set beats clear when both land on the same edge.
        exp_d = exp_q;
        if (wr_status && be[0] && wd[0])
            exp_d = 1'b0;
        if (expire)
            exp_d = 1'b1;

        presc_d = presc_q;
        if (wr_presc) begin
            if (be[0]) presc_d[7:0]  = wd[7:0];
            if (be[1]) presc_d[15:8] = wd[15:8];
        end

        reload_d = wr_reload ? merge_bytes(reload_q, wd, be) : reload_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q     <= 1'b0;
            ar_q     <= 1'b0;
            ie_q     <= 1'b0;
            exp_q    <= 1'b0;
            presc_q  <= 16'd0;
            pre_q    <= 16'd0;
            reload_q <= 32'd0;
            count_q  <= 32'd0;
        end else begin
            en_q     <= en_d;
            ar_q     <= ar_d;
            ie_q     <= ie_d;
            exp_q    <= exp_d;
            presc_q  <= presc_d;
            pre_q    <= pre_d;
            reload_q <= reload_d;
            count_q  <= count_d;
        end
    end

`ifdef SPMMIO_TIMER_CYCLES_EN
    logic [31:0] cycles_q, cycles_d;

    assign cycles_d = cycles_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset)
            cycles_q <= 32'd0;
        else
            cycles_q <= cycles_d;
    end
`endif

    always_comb begin
        rd = 32'd0;
        case (a)
            ADR_CTRL:     rd = {29'd0, ie_q, ar_q, en_q};
            ADR_STATUS:   rd = {31'd0, exp_q};
            ADR_PRESCALE: rd = {16'd0, presc_q};
            ADR_RELOAD:   rd = reload_q;
            ADR_COUNT:    rd = count_q;
`ifdef SPMMIO_TIMER_CYCLES_EN
            ADR_CYCLES:   rd = cycles_q;
`else
            ADR_CYCLES:   rd = 32'd0;
`endif
            default:      rd = 32'd0;
        endcase
    end

    assign irq = exp_q & ie_q;

endmodule

// File: tb/tb_spmmio_timer.sv
// Bench for spmmio_timer: directed register/timing scenarios plus a randomized run
// checked against a register-level behavioural model.
module tb_spmmio_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:3]  adr;
    logic        cs;
    logic [0:3]  sel;
    logic        we;
    logic [0:31] d;
    logic [0:31] q;
    logic        irq;

    int errors = 0;
    int checks = 0;

    spmmio_timer dut (
        .clk   (clk),
        .reset (reset),
        .adr   (adr),
        .cs    (cs),
        .sel   (sel),
        .we    (we),
        .d     (d),
        .q     (q),
        .irq   (irq)
    );

    always #50 clk = ~clk;

    // Reference model: architectural register contents only.
    logic        m_en, m_ar, m_ie, m_exp;
    logic [15:0] m_presc, m_phase;
    logic [31:0] m_reload, m_count;
`ifdef SPMMIO_TIMER_CYCLES_EN
    logic [31:0] m_cycles;
`endif

    function automatic logic [31:0] byte_mask(input logic [0:3] s);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 4; i++)
            if (s[3-i]) m = m | (32'hFF << (8*i));
        return m;
    endfunction

    task automatic model_step();
        logic [31:0] dv, mk;
        int          ai;
        logic        wr, tick, cwr, fire, zero;
        if (reset) begin
            m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
            m_presc = 0; m_phase = 0; m_reload = 0; m_count = 0;
`ifdef SPMMIO_TIMER_CYCLES_EN
            m_cycles = 0;
`endif
            return;
        end
        dv   = d;
        mk   = byte_mask(sel);
        ai   = int'(adr);
        wr   = cs && we;
        tick = m_en && (m_phase == m_presc);
        cwr  = wr && (ai == 4);
        fire = tick && !cwr;
        zero = (m_count == 0);
`ifdef SPMMIO_TIMER_CYCLES_EN
        m_cycles = m_cycles + 1;
`endif
        if (!m_en || (wr && ai == 2) || cwr)
            m_phase = 0;
        else
            m_phase = 16'((int'(m_phase) + 1) % (int'(m_presc) + 1));
        if (wr && ai == 1 && sel[3] && dv[0]) m_exp = 0;
        if (fire && zero) begin
            m_exp = 1;
            if (m_ar) m_count = m_reload;
            else      m_en = 0;
        end else if (fire) begin
            m_count = m_count - 1;
        end
        if (cwr) m_count = (m_count & ~mk) | (dv & mk);
        if (wr && ai == 0 && sel[3]) begin
            m_en = dv[0]; m_ar = dv[1]; m_ie = dv[2];
        end
        if (wr && ai == 2) m_presc = 16'(({16'd0, m_presc} & ~mk) | (dv & mk));
        if (wr && ai == 3) m_reload = (m_reload & ~mk) | (dv & mk);
    endtask

    function automatic logic [31:0] model_read(input int ai);
        case (ai)
            0: return {29'd0, m_ie, m_ar, m_en};
            1: return {31'd0, m_exp};
            2: return {16'd0, m_presc};
            3: return m_reload;
            4: return m_count;
`ifdef SPMMIO_TIMER_CYCLES_EN
            5: return m_cycles;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic rd_model(input int ai, input string tag);
        adr = 4'(ai); cs = 0; we = 0;
        #1;
        check(tag, q, model_read(ai));
    endtask

    task automatic rd_const(input int ai, input logic [31:0] exp, input string tag);
        adr = 4'(ai); cs = 0; we = 0;
        #1;
        check(tag, q, exp);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = 0; we = 0; reset = 0;
        step();
    endtask

    task automatic wr(input int ai, input logic [31:0] v, input logic [3:0] s);
        adr = 4'(ai); d = v; sel = s; cs = 1; we = 1;
        step();
        cs = 0; we = 0;
    endtask

    task automatic all_zero(input string tag);
        for (int i = 0; i < 16; i++) rd_const(i, 32'd0, tag);
        chk_irq(1'b0, tag);
    endtask

    initial begin
        reset = 1; cs = 0; we = 0; adr = 0; d = 0; sel = 0;
        step();
        step();
        reset = 0;
        all_zero("reset_reads");

        // One-shot: PRESCALE=3, COUNT=2 -> expiry 12 clocks after enabling
        wr(2, 32'd3, 4'hF);
        wr(4, 32'd2, 4'hF);
        wr(0, 32'd1, 4'hF);
        for (int k = 1; k <= 12; k++) begin
            idle();
            rd_const(1, (k == 12) ? 32'd1 : 32'd0, "oneshot_expired");
            rd_model(4, "oneshot_count_model");
        end
        rd_const(0, 32'd0, "oneshot_enable_cleared");
        rd_const(4, 32'd0, "oneshot_count_zero");
        wr(1, 32'd1, 4'b0001);
        rd_const(1, 32'd0, "status_clear");

        // Auto-reload every clock
        wr(2, 32'd0, 4'hF);
        wr(3, 32'd4, 4'hF);
        wr(4, 32'd0, 4'hF);
        wr(0, 32'd7, 4'hF);
        idle();
        rd_const(1, 32'd1, "reload_expired");
        chk_irq(1'b1, "reload_irq");
        rd_const(4, 32'd4, "reload_count0");
        begin
            logic [31:0] seq [5];
            seq[0] = 3; seq[1] = 2; seq[2] = 1; seq[3] = 0; seq[4] = 4;
            for (int k = 0; k < 5; k++) begin
                idle();
                rd_const(4, seq[k], "reload_count_seq");
            end
        end

        // STATUS clear drops irq; clear coincident with expiry loses
        wr(1, 32'd1, 4'b0001);
        chk_irq(1'b0, "irq_cleared");
        rd_const(4, 32'd3, "clear_count");
        idle(); idle(); idle();
        rd_const(4, 32'd0, "pre_expiry_count");
        wr(1, 32'd1, 4'b0001);
        rd_const(1, 32'd1, "set_beats_clear");
        chk_irq(1'b1, "set_beats_clear_irq");
        wr(0, 32'd0, 4'hF);
        wr(1, 32'd1, 4'hF);
        chk_irq(1'b0, "stopped_irq");

        // Byte-lane write
        wr(4, 32'h11223344, 4'hF);
        wr(4, 32'hAABBCCDD, 4'b0101);
        rd_const(4, 32'h11BB33DD, "count_byte_lanes");

        // COUNT write on a tick wins
        wr(2, 32'd0, 4'hF);
        wr(4, 32'h20, 4'hF);
        wr(0, 32'd1, 4'hF);
        idle(); idle();
        rd_const(4, 32'h1E, "running_count");
        wr(4, 32'h10, 4'hF);
        rd_const(4, 32'h10, "count_write_wins");
        idle();
        rd_const(4, 32'h0F, "count_after_write");
        wr(0, 32'd0, 4'hF);

        // Reset mid-countdown with a coincident write
        wr(2, 32'd1, 4'hF);
        wr(4, 32'd100, 4'hF);
        wr(0, 32'd7, 4'hF);
        for (int k = 0; k < 5; k++) idle();
        reset = 1; adr = 4; d = 32'd55; sel = 4'hF; cs = 1; we = 1;
        step();
        reset = 0; cs = 0; we = 0;
        all_zero("midcount_reset");
        for (int k = 0; k < 5; k++) idle();
`ifdef SPMMIO_TIMER_CYCLES_EN
        rd_const(5, 32'd5, "cycles_after_reset");
`else
        rd_const(5, 32'd0, "cycles_absent");
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int ra;
            ra    = $urandom_range(0, 7);
            reset = ($urandom_range(0, 63) == 0);
            cs    = ($urandom_range(0, 2) == 0);
            we    = ($urandom_range(0, 3) != 0);
            adr   = 4'(ra);
            case (ra)
                0:       d = 32'($urandom_range(0, 7));
                1:       d = 32'($urandom_range(0, 1));
                2:       d = 32'($urandom_range(0, 3));
                3, 4:    d = 32'($urandom_range(0, 12));
                default: d = $urandom;
            endcase
            sel = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            step();
            reset = 0; cs = 0; we = 0;
            rd_model($urandom_range(0, 7), "rand_read");
            rd_model(4, "rand_count");
            chk_irq(m_exp & m_ie, "rand_irq");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spmmio_timer.md
SPMMIO_TIMER -- requirements
Module: spmmio_timer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 adr  input  [0:3]  word index within the peripheral slot; adr[3] is the least significant bit.
REQ-005 cs  input  1  access strobe, already qualified by cyc/stb in the MMIO decoder.
REQ-006 sel  input  [0:3]  byte enables; sel[0] maps to d[0:7], ..., sel[3] maps to d[24:31].
REQ-007 we  input  1  write when high and cs is high.
REQ-008 d  input  [0:31]  write data; bit 31 is the LSB.
REQ-009 q  output  [0:31]  read data, combinational from adr and register state, independent of cs.
REQ-010 irq  output  1  level interrupt, equal to EXPIRED AND IRQEN.

Function
REQ-011 The block SHALL accept single-cycle zero-wait accesses: a write takes effect on the clk edge where cs and we are both high, and a read is valid in the same cycle.
REQ-012 The register map SHALL be: 0 CTRL, 1 STATUS, 2 PRESCALE, 3 RELOAD, 4 COUNT, 5 CYCLES; reads from addresses 6-15 SHALL return 0, and writes to them are ignored.
REQ-013 CTRL SHALL hold ENABLE in d[31], AUTORELOAD in d[30] and IRQEN in d[29]; all other bits read 0.
REQ-014 STATUS SHALL hold EXPIRED in d[31]; writing 1 to d[31] with sel[3] set SHALL clear it, and writing 0 SHALL have no effect.
REQ-015 PRESCALE SHALL be 16 bits in d[16:31], with d[0:15] reading 0; RELOAD and COUNT SHALL be 32 bits.
REQ-016 Every writable register SHALL update only the bytes whose sel bit is set.
REQ-017 An internal 16-bit prescaler counter SHALL increment each clk while ENABLE=1.
REQ-018 When the prescaler counter equals PRESCALE, it SHALL wrap to 0 and generate a one-cycle tick, giving one tick every PRESCALE+1 clocks.
REQ-019 The prescaler counter SHALL be forced to 0 when ENABLE is 0, when PRESCALE is written, or when COUNT is written.
REQ-020 On a tick with COUNT != 0, COUNT SHALL decrement by 1.
REQ-021 On a tick with COUNT == 0, EXPIRED SHALL be set; if AUTORELOAD=1, COUNT SHALL load RELOAD; otherwise COUNT SHALL remain 0 and ENABLE SHALL clear (one-shot).
REQ-022 COUNT SHALL wrap only via reload and SHALL never underflow to 0xFFFFFFFF.
REQ-023 If a COUNT write coincides with a tick, the written value SHALL win and the tick SHALL be discarded.
REQ-024 If a CTRL write coincides with a one-shot auto-clear of ENABLE, the CTRL write SHALL win.
REQ-025 If an EXPIRED set coincides with a STATUS clear write, EXPIRED SHALL remain 1.
REQ-026 Reads of COUNT, STATUS and CYCLES SHALL return the pre-edge register value (the value before the current clk edge).
REQ-027 irq SHALL be combinational from the registered EXPIRED and IRQEN bits, with no additional latency.

Reset
REQ-028 On reset, CTRL, STATUS, PRESCALE, RELOAD, COUNT, CYCLES and the prescaler counter SHALL all be 0.
REQ-029 As a consequence of REQ-028, irq SHALL be 0 out of reset, and q SHALL read 0 at every address.
REQ-030 Reset asserted mid-count SHALL override any coincident write or tick.

Configuration
REQ-031 With SPMMIO_TIMER_CYCLES_EN defined, CYCLES SHALL be a 32-bit free-running counter, incremented every clk regardless of ENABLE, wrapping from 0xFFFFFFFF to 0, and read-only.
REQ-032 With SPMMIO_TIMER_CYCLES_EN undefined, the CYCLES counter SHALL not be instantiated, and address 5 SHALL read 0.

Verification
REQ-033 Write PRESCALE=3, COUNT=2 and CTRL=0x1 -> EXPIRED rises exactly 12 clocks after the CTRL write edge, ENABLE then reads 0, and COUNT reads 0.
REQ-034 Write PRESCALE=0, RELOAD=4, COUNT=0 and CTRL=0x7 -> EXPIRED rises 1 clock later, irq rises in the same cycle, and COUNT reads 4, 3, 2, 1, 0, 4 on successive clocks.
REQ-035 While irq=1, write STATUS=0x1 with sel=4'b0001 -> irq drops 1 cycle later; write STATUS=0x1 in the same cycle as an expiry tick -> EXPIRED stays 1.
REQ-036 Write COUNT=0xAABBCCDD with sel=4'b0101 over old value 0x11223344 -> COUNT reads 0x11BB33DD.
REQ-037 While running with PRESCALE=0, write COUNT=0x10 on a tick cycle -> COUNT reads 0x10 next cycle, then 0x0F one cycle later.
REQ-038 Assert reset for 1 cycle mid-countdown -> all reads return 0 and irq=0; with SPMMIO_TIMER_CYCLES_EN defined, CYCLES reads N after N clocks post-reset, and without the macro it reads 0.
